sequenciador_animacao: RTL and testbench

//  Parametrised successor to the image controller. Streams 1024-byte OLED frames (128x64, 8 rows x 128 cols, byte_idx = row*128+col is
//  not used; index = page-major 0..1023) for N_ANIM animations, each with its own frame count, from one flat ROM.

---
 rtl/tamagotchi_pkg.sv | 34 +++
 rtl/sequenciador_animacao_barra_status.sv | 29 ++
 rtl/sequenciador_animacao.sv | 185 ++++++++++++++++++
 tb/tb_sequenciador_animacao.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tamagotchi_pkg.sv
// Shared constants for the animation sequencer: estado encodings, per-animation
// frame counts, ROM layout, bar segment bytes and the sequencer state type.
package tamagotchi_pkg;

  localparam int unsigned N_ANIM_PKG  = 5;
  localparam int unsigned FRAME_BYTES = 1024;
  localparam int unsigned ROM_AW      = 15;   // 30 frames x 1024 bytes

  typedef enum logic [4:0] {
    IDLE       = 5'b00001,
    DORMINDO   = 5'b00010,
    COMENDO    = 5'b00100,
    DANDO_AULA = 5'b01000,
    MORTO      = 5'b10000
  } estado_e;

  localparam int unsigned FRAMES    [N_ANIM_PKG] = '{6, 4, 4, 8, 8};
  localparam int unsigned ANIM_BASE [N_ANIM_PKG] = '{0, 6144, 10240, 14336, 22528};

  localparam logic [7:0] BAR_FULL = 8'hEE;
  localparam logic [7:0] BAR_HALF = 8'hE0;

  typedef enum logic {
    SEQ_HOLD,
    SEQ_ADVANCE
  } seq_state_e;

  // Frame image contents: each 1 KiB frame gets a distinct, address-derived
  // pattern so animation/frame selection is observable on data_out.
  function automatic logic [7:0] rom_byte(input logic [ROM_AW-1:0] addr);
    return {addr[14:10], 3'b000} ^ addr[7:0] ^ {6'b000000, addr[9:8]};
  endfunction

endpackage

// File: rtl/sequenciador_animacao_barra_status.sv
// barra_status: combinational segment byte for one status-bar column.
// level is expected already clamped to 0..100; col 1..5 are the segments.
module barra_status
  import tamagotchi_pkg::*;
(
  input  logic [6:0] level,
  input  logic [2:0] col,
  output logic [7:0] pattern
);

  logic [7:0] full_thr;
  logic [7:0] half_thr;

  // Segment c is full above 110-20c, half above 100-20c, otherwise dark.
  always_comb begin
    full_thr = 8'd0;
    half_thr = 8'd0;
    pattern  = 8'h00;
    if (col >= 3'd1 && col <= 3'd5) begin
      full_thr = 8'd110 - 8'd20 * {5'd0, col};
      half_thr = 8'd100 - 8'd20 * {5'd0, col};
      if ({1'b0, level} > full_thr)
        pattern = BAR_FULL;
      else if ({1'b0, level} > half_thr)
        pattern = BAR_HALF;
    end
  end

endmodule

// File: rtl/sequenciador_animacao.sv
// sequenciador_animacao: streams OLED frame bytes for the active animation,
// switching/advancing frames only at frame_start, with runtime status bars
// overlaid. Optional feature macro: BAR_BLINK_EN (low bars blink per advance).
module sequenciador_animacao
  import tamagotchi_pkg::*;
#(
  parameter int unsigned       N_ANIM      = 5,
  parameter int unsigned       MAX_FRAMES  = 8,
  parameter int unsigned       FRAME_TICKS = 8388608,
  parameter logic [N_ANIM-1:0] LOOP_MASK   = 5'b01111,
  parameter int unsigned       N_BARS      = 3,
  parameter int unsigned       BAR_ROW0    = 8,
  localparam int unsigned      FRAME_W     = $clog2(MAX_FRAMES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  logic                  byte_req,
  input  logic [9:0]            byte_idx,
  input  logic [N_ANIM-1:0]     estado,
  input  logic [7*N_BARS-1:0]   levels,
  output logic [7:0]            data_out,
  output logic                  data_valid,
  output logic [FRAME_W-1:0]    frame_idx,
  output logic                  anim_done
);

  localparam int unsigned ANIM_W = $clog2(N_ANIM);
  localparam int unsigned TICK_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(FRAME_TICKS - 1);

  logic [TICK_W-1:0]  tick_cnt;
  logic               tick_wrap;
  logic [ANIM_W-1:0]  req_anim;
  logic               hot_found;
  logic               hot_multi;

  seq_state_e         state, state_nxt;
  logic [ANIM_W-1:0]  anim_q, anim_nxt;
  logic [FRAME_W-1:0] frame_nxt, frame_inc, last_frame;
  logic               done_nxt;

  logic [6:0]         grp;
  logic [2:0]         col;
  logic               bar_hit;
  logic [6:0]         bar_level;
  logic [7:0]         bar_pattern;
  logic               bar_blank;
  logic [ROM_AW-1:0]  rom_addr;
  logic [7:0]         rom_q;
  logic [7:0]         ovl_q;
  logic               ovl_sel;

  assign tick_wrap = (tick_cnt == TICK_LAST);

  // Free-running frame-period counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         tick_cnt <= '0;
    else if (tick_wrap) tick_cnt <= '0;
    else                tick_cnt <= tick_cnt + 1'b1;
  end

  // One-hot estado decode; zero or multi-hot falls back to animation 0.
  always_comb begin
    req_anim  = '0;
    hot_found = 1'b0;
    hot_multi = 1'b0;
    for (int unsigned a = 0; a < N_ANIM; a++) begin
      if (estado[a]) begin
        if (hot_found) hot_multi = 1'b1;
        hot_found = 1'b1;
        req_anim  = ANIM_W'(a);
      end
    end
    if (!hot_found || hot_multi) req_anim = '0;
  end

  assign last_frame = FRAME_W'(FRAMES[anim_q] - 1);
  assign frame_inc  = frame_idx + 1'b1;

  // Sequencer state: SEQ_ADVANCE holds a pending advance until a frame_start
  // consumes it; a wrap coinciding with frame_start is consumed immediately.
  always_comb begin
    state_nxt = state;
    anim_nxt  = anim_q;
    frame_nxt = frame_idx;
    done_nxt  = anim_done;
    if (tick_wrap) state_nxt = SEQ_ADVANCE;
    if (frame_start) begin
      state_nxt = SEQ_HOLD;
      if (req_anim != anim_q) begin
        anim_nxt  = req_anim;
        frame_nxt = '0;
        done_nxt  = 1'b0;
      end else if (state == SEQ_ADVANCE || tick_wrap) begin
        if (LOOP_MASK[anim_q]) begin
          frame_nxt = (frame_idx == last_frame) ? '0 : frame_inc;
        end else if (frame_idx != last_frame) begin
          frame_nxt = frame_inc;
          done_nxt  = (frame_inc == last_frame);
        end else begin
          done_nxt  = 1'b1;
        end
      end
    end
  end

  // Sequencer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SEQ_HOLD;
      anim_q    <= '0;
      frame_idx <= '0;
      anim_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      anim_q    <= anim_nxt;
      frame_idx <= frame_nxt;
      anim_done <= done_nxt;
    end
  end

  assign grp = byte_idx[9:3];
  assign col = byte_idx[2:0];

  // Bar hit test and level select (clamped to 100) for the requested byte.
  always_comb begin
    bar_hit   = 1'b0;
    bar_level = '0;
    for (int unsigned b = 0; b < N_BARS; b++) begin
      if (32'(grp) >= BAR_ROW0 + 10 * b && 32'(grp) <= BAR_ROW0 + 10 * b + 4 &&
          col >= 3'd1 && col <= 3'd5) begin
        bar_hit   = 1'b1;
        bar_level = levels[7*b +: 7];
      end
    end
    if (bar_level > 7'd100) bar_level = 7'd100;
  end

  barra_status u_barra (
    .level   (bar_level),
    .col     (col),
    .pattern (bar_pattern)
  );

`ifdef BAR_BLINK_EN
  logic blink_off;
  logic adv_take;

  assign adv_take = frame_start && (req_anim == anim_q) &&
                    (state == SEQ_ADVANCE || tick_wrap);

  // Blink phase flips on every consumed advance; starts visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        blink_off <= 1'b0;
    else if (adv_take) blink_off <= ~blink_off;
  end

  assign bar_blank = blink_off && (bar_level < 7'd20);
`else
  assign bar_blank = 1'b0;
`endif

  assign rom_addr = ROM_AW'(ANIM_BASE[anim_q] + FRAME_BYTES * 32'(frame_idx) + 32'(byte_idx));

  // ROM read and overlay decision registered together; outputs hold between requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_q      <= '0;
      ovl_q      <= '0;
      ovl_sel    <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= byte_req;
      if (byte_req) begin
        rom_q   <= rom_byte(rom_addr);
        ovl_sel <= bar_hit;
        ovl_q   <= bar_blank ? 8'h00 : bar_pattern;
      end
    end
  end

  assign data_out = ovl_sel ? ovl_q : rom_q;

endmodule

// File: tb/tb_sequenciador_animacao.sv
// Self-checking bench for sequenciador_animacao (FRAME_TICKS=4).
module tb_sequenciador_animacao;
  import tamagotchi_pkg::*;

  localparam int unsigned TICKS = 4;
  localparam int unsigned TB_FRAMES [5] = '{6, 4, 4, 8, 8};
  localparam logic [4:0]  TB_LOOP = 5'b01111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_start;
  logic        byte_req;
  logic [9:0]  byte_idx;
  logic [4:0]  estado;
  logic [20:0] levels;
  logic [7:0]  data_out;
  logic        data_valid;
  logic [2:0]  frame_idx;
  logic        anim_done;

  sequenciador_animacao #(.FRAME_TICKS(TICKS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .byte_req    (byte_req),
    .byte_idx    (byte_idx),
    .estado      (estado),
    .levels      (levels),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .frame_idx   (frame_idx),
    .anim_done   (anim_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q [$];

  int unsigned m_anim, m_frame, m_tick;
  bit m_done, m_pend, m_blink;

  typedef struct {
    logic [9:0] idx;
    logic [6:0] l0, l1, l2;
    bit         use_rom;
    logic [7:0] expv;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic int unsigned decode(input logic [4:0] e);
    case (e)
      5'b00001: return 0;
      5'b00010: return 1;
      5'b00100: return 2;
      5'b01000: return 3;
      5'b10000: return 4;
      default:  return 0;
    endcase
  endfunction

  function automatic int unsigned base_of(input int unsigned a);
    int unsigned s = 0;
    for (int unsigned i = 0; i < a; i++) s += TB_FRAMES[i] * 1024;
    return s;
  endfunction

  function automatic logic [7:0] rom_model(input int unsigned addr);
    logic [14:0] ad;
    ad = addr[14:0];
    return {ad[14:10], 3'b000} ^ ad[7:0] ^ {6'b000000, ad[9:8]};
  endfunction

  function automatic logic [7:0] exp_byte(input logic [9:0] idx);
    int g, c, lvl;
    g = int'(idx) / 8;
    c = int'(idx) % 8;
    for (int b = 0; b < 3; b++) begin
      if (g >= 8 + 10*b && g <= 12 + 10*b && c >= 1 && c <= 5) begin
        lvl = int'(levels[7*b +: 7]);
        if (lvl > 100) lvl = 100;
`ifdef BAR_BLINK_EN
        if (m_blink && lvl < 20) return 8'h00;
`endif
        if (lvl > 110 - 20*c) return 8'hEE;
        if (lvl > 100 - 20*c) return 8'hE0;
        return 8'h00;
      end
    end
    return rom_model(base_of(m_anim) + m_frame * 1024 + int'(idx));
  endfunction

  task automatic model_edge(input logic fs);
    bit wrap;
    int unsigned ra;
    wrap   = (m_tick == TICKS - 1);
    m_tick = wrap ? 0 : m_tick + 1;
    if (fs) begin
      ra = decode(estado);
      if (ra != m_anim) begin
        m_anim = ra; m_frame = 0; m_done = 0;
      end else if (m_pend || wrap) begin
        m_blink = !m_blink;
        if (TB_LOOP[m_anim])
          m_frame = (m_frame + 1) % TB_FRAMES[m_anim];
        else if (m_frame + 1 < TB_FRAMES[m_anim]) begin
          m_frame++;
          if (m_frame == TB_FRAMES[m_anim] - 1) m_done = 1;
        end else
          m_done = 1;
      end
      m_pend = 0;
    end else if (wrap) begin
      m_pend = 1;
    end
  endtask

  task automatic model_reset();
    m_anim = 0; m_frame = 0; m_tick = 0;
    m_done = 0; m_pend = 0; m_blink = 0;
    exp_q.delete();
  endtask

  // One clock: drive, push expectation, advance model, then check after the edge.
  task automatic cyc(input logic fs, input logic req, input logic [9:0] idx, input int exp_ovr = -1);
    frame_start = fs;
    byte_req    = req;
    byte_idx    = idx;
    if (req) exp_q.push_back((exp_ovr < 0) ? exp_byte(idx) : 8'(exp_ovr));
    model_edge(fs);
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    byte_req    = 1'b0;
    check("data_valid", data_valid, req);
    if (data_valid) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL scoreboard: got %0h expected nothing", data_out);
      end else
        check("data_out", data_out, exp_q.pop_front());
    end else if (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
    end
    check("frame_idx", frame_idx, m_frame);
    check("anim_done", anim_done, m_done);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; frame_start = 1'b0; byte_req = 1'b0; byte_idx = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  vec_t vecs [];
  int unsigned exp_seq [7] = '{1, 2, 3, 4, 5, 0, 1};

  initial begin
    vecs = new[16];
    vecs[0]  = '{10'd66,  7'd65,  7'd0,   7'd0,  1'b0, 8'hE0};
    vecs[1]  = '{10'd66,  7'd71,  7'd0,   7'd0,  1'b0, 8'hEE};
    vecs[2]  = '{10'd66,  7'd0,   7'd0,   7'd0,  1'b0, 8'h00};
    vecs[3]  = '{10'd65,  7'd100, 7'd0,   7'd0,  1'b0, 8'hEE};
    vecs[4]  = '{10'd65,  7'd85,  7'd0,   7'd0,  1'b0, 8'hE0};
    vecs[5]  = '{10'd69,  7'd5,   7'd0,   7'd0,  1'b0, 8'hE0};
    vecs[6]  = '{10'd69,  7'd11,  7'd0,   7'd0,  1'b0, 8'hEE};
    vecs[7]  = '{10'd101, 7'd100, 7'd0,   7'd0,  1'b0, 8'hEE};
    vecs[8]  = '{10'd147, 7'd0,   7'd127, 7'd0,  1'b0, 8'hEE};
    vecs[9]  = '{10'd227, 7'd0,   7'd0,   7'd55, 1'b0, 8'hEE};
    vecs[10] = '{10'd227, 7'd0,   7'd0,   7'd45, 1'b0, 8'hE0};
    vecs[11] = '{10'd259, 7'd0,   7'd0,   7'd41, 1'b0, 8'hE0};
    vecs[12] = '{10'd130, 7'd100, 7'd100, 7'd100, 1'b0, 8'h82};
    vecs[13] = '{10'd104, 7'd100, 7'd0,   7'd0,  1'b0, 8'h68};
    vecs[14] = '{10'd70,  7'd100, 7'd0,   7'd0,  1'b1, 8'h00};
    vecs[15] = '{10'd1023, 7'd0,  7'd0,   7'd0,  1'b1, 8'h00};

    estado = IDLE;
    levels = '0;
    do_reset();

    // Reset state
    check("rst_data_out", data_out, 8'h00);
    check("rst_valid", data_valid, 1'b0);
    check("rst_frame", frame_idx, 3'd0);
    check("rst_done", anim_done, 1'b0);

    // Overlay / ROM vectors in anim 0 frame 0
    for (int unsigned i = 0; i < vecs.size(); i++) begin
      levels = {vecs[i].l2, vecs[i].l1, vecs[i].l0};
      cyc(1'b0, 1'b1, vecs[i].idx, vecs[i].use_rom ? -1 : int'(vecs[i].expv));
    end
    cyc(1'b0, 1'b0, 10'd0);
    check("hold_data", data_out, rom_model(1023));

    // Looping IDLE wraps 0..5 -> 0
    levels = '0;
    for (int unsigned k = 0; k < 7; k++) begin
      cyc(1'b1, 1'b0, 10'd0);
      check("frame_seq", frame_idx, exp_seq[k]);
      for (int unsigned j = 0; j < 3; j++) cyc(1'b0, 1'b1, 10'(k * 37 + j * 300));
    end

    // estado change mid-frame has no effect until frame_start
    cyc(1'b1, 1'b0, 10'd0);
    for (int unsigned i = 498; i <= 500; i++) cyc(1'b0, 1'b1, 10'(i));
    estado = MORTO;
    for (int unsigned i = 501; i <= 504; i++) cyc(1'b0, 1'b1, 10'(i));
    cyc(1'b0, 1'b1, 10'd1023);
    cyc(1'b1, 1'b0, 10'd0);
    check("morto_frame0", frame_idx, 3'd0);
    cyc(1'b0, 1'b1, 10'd3, 8'hB3);

    // MORTO one-shot saturates at 7 with anim_done
    for (int unsigned k = 0; k < 10; k++) begin
      cyc(1'b1, 1'b0, 10'd0);
      repeat (3) cyc(1'b0, 1'b0, 10'd0);
    end
    check("oneshot_frame", frame_idx, 3'd7);
    check("oneshot_done", anim_done, 1'b1);
    estado = IDLE;
    cyc(1'b1, 1'b0, 10'd0);
    check("switch_done_clr", anim_done, 1'b0);
    check("switch_frame", frame_idx, 3'd0);

    // Zero and multi-hot estado select animation 0
    estado = MORTO;
    cyc(1'b1, 1'b0, 10'd0);
    estado = 5'b00000;
    cyc(1'b1, 1'b0, 10'd0);
    cyc(1'b0, 1'b1, 10'd5, 8'h05);
    cyc(1'b0, 1'b0, 10'd0);
    estado = 5'b10001;
    cyc(1'b1, 1'b0, 10'd0);
    cyc(1'b0, 1'b1, 10'd5, 8'h0D);
    estado = IDLE;

    // Low bar 1 (level 15) segment c=5 across advances
    levels = {7'd0, 7'd15, 7'd0};
    for (int unsigned k = 0; k < 4; k++) begin
      cyc(1'b1, 1'b0, 10'd0);
`ifdef BAR_BLINK_EN
      cyc(1'b0, 1'b1, 10'd149);
`else
      cyc(1'b0, 1'b1, 10'd149, 8'hEE);
`endif
      repeat (2) cyc(1'b0, 1'b0, 10'd0);
    end

    // Asynchronous reset mid-frame
    estado = MORTO;
    levels = {7'd0, 7'd0, 7'd127};
    cyc(1'b1, 1'b0, 10'd0);
    cyc(1'b0, 1'b1, 10'd66, 8'hEE);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_data_out", data_out, 8'h00);
    check("async_valid", data_valid, 1'b0);
    check("async_frame", frame_idx, 3'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    estado = IDLE;
    cyc(1'b0, 1'b1, 10'd66, 8'hEE);
    cyc(1'b0, 1'b1, 10'd69, 8'hEE);
    cyc(1'b0, 1'b1, 10'd2, 8'h02);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
